buffer_memory: RTL and testbench

Parameterised pipeline buffer register placed between two processor pipeline stages. It captures `data_in` every clock and presents it on `data_out` after a configurable number of stages. A `flush` input turns all in-flight contents into zero-valued bubbles. Reset is synchronous and clears every stage.

---
 rtl/buffer_memory_pkg.sv | 28 ++
 rtl/buffer_stage.sv | 52 +++++
 rtl/buffer_memory.sv | 77 +++++++
 tb/tb_buffer_memory.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/buffer_memory_pkg.sv
// -----------------------------------------------------------------------------
// buffer_memory_pkg
// Shared defaults for the buffer_memory pipeline register.
//   BM_DATA_WIDTH_DEFAULT : default data path width
//   BM_DEPTH_DEFAULT      : default number of register stages (= latency)
//   BM_FLUSH_CNT_WIDTH    : width of the optional flush counter
// -----------------------------------------------------------------------------
package buffer_memory_pkg;

   localparam int BM_DATA_WIDTH_DEFAULT = 64;
   localparam int BM_DEPTH_DEFAULT      = 1;
   localparam int BM_FLUSH_CNT_WIDTH    = 16;

   // Per-stage operation selected at each edge, in priority order.
   typedef enum logic [1:0] {
      STG_RESET = 2'd0,
      STG_FLUSH = 2'd1,
      STG_LOAD  = 2'd2
   } stage_op_e;

   // Resolve rst > flush > load priority in one place so every stage agrees.
   function automatic stage_op_e stage_op(input logic rst, input logic flush);
      if (rst)        return STG_RESET;
      else if (flush) return STG_FLUSH;
      else            return STG_LOAD;
   endfunction

endpackage

// File: rtl/buffer_stage.sv
// -----------------------------------------------------------------------------
// buffer_stage
// One pipeline register: a data word plus its valid bit. On reset or flush the
// stage becomes a bubble (FLUSH_VALUE, valid=0); otherwise it loads its input.
// Ports:
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset
//   flush   : synchronous active-high flush
//   i_data  : data from the previous stage (or the buffer input)
//   i_vld   : valid from the previous stage (tied high for stage 0)
//   o_data  : registered data
//   o_vld   : registered valid
// -----------------------------------------------------------------------------
module buffer_stage
   import buffer_memory_pkg::*;
#(
   parameter int                    DATA_WIDTH  = BM_DATA_WIDTH_DEFAULT,
   parameter logic [DATA_WIDTH-1:0] FLUSH_VALUE = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_vld,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_vld
);

   logic [DATA_WIDTH-1:0] r_data;
   logic                  r_vld;
   stage_op_e             w_op;

   assign w_op = stage_op(rst, flush);

   always_ff @(posedge clk) begin
      case (w_op)
         STG_RESET,
         STG_FLUSH: begin
            r_data <= FLUSH_VALUE;
            r_vld  <= 1'b0;
         end
         default: begin
            r_data <= i_data;
            r_vld  <= i_vld;
         end
      endcase
   end

   assign o_data = r_data;
   assign o_vld  = r_vld;

endmodule

// File: rtl/buffer_memory.sv
// -----------------------------------------------------------------------------
// buffer_memory
// Parameterised pipeline buffer between two processor stages. data_in is
// captured every edge and emerges on data_out DEPTH edges later. flush turns
// all in-flight contents into bubbles; rst does the same and also clears the
// optional flush counter. No handshake, no stall: the chain advances always.
//
// Parameters: DATA_WIDTH (>=1), DEPTH (>=1, latency), FLUSH_VALUE
// Ports:
//   clk         : clock, rising edge
//   rst         : synchronous active-high reset
//   flush       : synchronous active-high flush
//   data_in     : input word, captured into stage 0
//   data_out    : last stage contents (registered)
//   valid_out   : last stage holds captured data (registered)
//   flush_count : 16-bit saturating count of flush edges, only when the
//                 macro BUFFER_MEMORY_FLUSH_CNT_EN is defined
// -----------------------------------------------------------------------------
module buffer_memory
   import buffer_memory_pkg::*;
#(
   parameter int                    DATA_WIDTH  = BM_DATA_WIDTH_DEFAULT,
   parameter int                    DEPTH       = BM_DEPTH_DEFAULT,
   parameter logic [DATA_WIDTH-1:0] FLUSH_VALUE = '0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          flush,
   input  logic [DATA_WIDTH-1:0]         data_in,
   output logic [DATA_WIDTH-1:0]         data_out,
   output logic                          valid_out
`ifdef BUFFER_MEMORY_FLUSH_CNT_EN
   ,
   output logic [BM_FLUSH_CNT_WIDTH-1:0] flush_count
`endif
);

   // Chain taps: index 0 is the buffer input, index i+1 is stage i's output.
   logic [DATA_WIDTH-1:0] w_data [0:DEPTH];
   logic                  w_vld  [0:DEPTH];

   assign w_data[0] = data_in;
   assign w_vld[0]  = 1'b1;   // anything loaded into stage 0 is real data

   for (genvar g = 0; g < DEPTH; g++) begin : g_stage
      buffer_stage #(
         .DATA_WIDTH  (DATA_WIDTH),
         .FLUSH_VALUE (FLUSH_VALUE)
      ) u_stage (
         .clk    (clk),
         .rst    (rst),
         .flush  (flush),
         .i_data (w_data[g]),
         .i_vld  (w_vld[g]),
         .o_data (w_data[g+1]),
         .o_vld  (w_vld[g+1])
      );
   end

   assign data_out  = w_data[DEPTH];
   assign valid_out = w_vld[DEPTH];

`ifdef BUFFER_MEMORY_FLUSH_CNT_EN
   logic [BM_FLUSH_CNT_WIDTH-1:0] r_flush_cnt;

   // rst wins over flush, so a simultaneous rst+flush clears rather than counts.
   always_ff @(posedge clk) begin
      if (rst)
         r_flush_cnt <= '0;
      else if (flush && (r_flush_cnt != '1))
         r_flush_cnt <= r_flush_cnt + 1'b1;
   end

   assign flush_count = r_flush_cnt;
`endif

endmodule

// File: tb/tb_buffer_memory.sv
// Directed bench: two instances (DEPTH=1 and DEPTH=3) share the same inputs.
// Inputs are driven at the falling edge; outputs are sampled one falling edge
// later, i.e. after the rising edge that consumed the inputs.
module tb_buffer_memory;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        flush = 1'b0;
   logic [63:0] data_in = '0;
   logic [63:0] d1, d3;
   logic        v1, v3;
`ifdef BUFFER_MEMORY_FLUSH_CNT_EN
   logic [15:0] c1, c3;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   buffer_memory #(.DATA_WIDTH(64), .DEPTH(1)) u_d1 (
      .clk(clk), .rst(rst), .flush(flush), .data_in(data_in),
      .data_out(d1), .valid_out(v1)
`ifdef BUFFER_MEMORY_FLUSH_CNT_EN
      , .flush_count(c1)
`endif
   );

   buffer_memory #(.DATA_WIDTH(64), .DEPTH(3)) u_d3 (
      .clk(clk), .rst(rst), .flush(flush), .data_in(data_in),
      .data_out(d3), .valid_out(v3)
`ifdef BUFFER_MEMORY_FLUSH_CNT_EN
      , .flush_count(c3)
`endif
   );

   typedef struct {
      logic        rst;
      logic        flush;
      logic [63:0] din;
      logic [63:0] e1;
      logic        e1v;
      logic [63:0] e3;
      logic        e3v;
      logic [15:0] ecnt;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", name, act, exp);
      end
   endtask

   task automatic step(input logic r, input logic f, input logic [63:0] d);
      rst = r; flush = f; data_in = d;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic add(input logic r, input logic f, input logic [63:0] d,
                      input logic [63:0] e1, input logic e1v,
                      input logic [63:0] e3, input logic e3v, input logic [15:0] ec);
      vec_t v;
      v.rst = r; v.flush = f; v.din = d;
      v.e1 = e1; v.e1v = e1v; v.e3 = e3; v.e3v = e3v; v.ecnt = ec;
      tbl.push_back(v);
   endtask

   initial begin
      int lat;
      //   rst flush din            d1 out         v1  d3 out  v3  cnt
      add(1, 0, 64'd0,           64'd0,          0,  64'd0,  0,  0);  // reset
      add(1, 0, 64'd0,           64'd0,          0,  64'd0,  0,  0);
      add(0, 0, 64'd20,          64'd20,         1,  64'd0,  0,  0);  // pass-through
      add(0, 0, 64'd22,          64'd22,         1,  64'd0,  0,  0);
      add(0, 0, 64'd22,          64'd22,         1,  64'd20, 1,  0);
      add(0, 1, 64'd50,          64'd0,          0,  64'd0,  0,  1);  // flush x2
      add(0, 1, 64'd50,          64'd0,          0,  64'd0,  0,  2);
      add(0, 0, 64'd50,          64'd50,         1,  64'd0,  0,  2);
      add(0, 0, 64'd1,           64'd1,          1,  64'd0,  0,  2);  // depth stream
      add(0, 0, 64'd2,           64'd2,          1,  64'd50, 1,  2);
      add(0, 0, 64'd3,           64'd3,          1,  64'd1,  1,  2);
      add(0, 0, 64'd4,           64'd4,          1,  64'd2,  1,  2);
      add(0, 1, 64'd9,           64'd0,          0,  64'd0,  0,  3);  // mid-stream flush
      add(0, 0, 64'd5,           64'd5,          1,  64'd0,  0,  3);
      add(0, 0, 64'd6,           64'd6,          1,  64'd0,  0,  3);
      add(0, 0, 64'd7,           64'd7,          1,  64'd5,  1,  3);
      add(1, 1, 64'd50,          64'd0,          0,  64'd0,  0,  0);  // rst+flush
      add(0, 0, 64'd50,          64'd50,         1,  64'd0,  0,  0);
      add(0, 0, 64'd51,          64'd51,         1,  64'd0,  0,  0);
      add(0, 0, 64'd52,          64'd52,         1,  64'd50, 1,  0);
      add(0, 0, 64'hDEADBEEFCAFEF00D, 64'hDEADBEEFCAFEF00D, 1, 64'd51, 1, 0);
      add(0, 0, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1, 64'd52, 1, 0);

      @(negedge clk);
      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].rst, tbl[i].flush, tbl[i].din);
         chk($sformatf("v%0d.d1_data", i), d1, tbl[i].e1);
         chk($sformatf("v%0d.d1_vld", i), {63'd0, v1}, {63'd0, tbl[i].e1v});
         chk($sformatf("v%0d.d3_data", i), d3, tbl[i].e3);
         chk($sformatf("v%0d.d3_vld", i), {63'd0, v3}, {63'd0, tbl[i].e3v});
`ifdef BUFFER_MEMORY_FLUSH_CNT_EN
         chk($sformatf("v%0d.cnt1", i), {48'd0, c1}, {48'd0, tbl[i].ecnt});
         chk($sformatf("v%0d.cnt3", i), {48'd0, c3}, {48'd0, tbl[i].ecnt});
`endif
      end

      // Held flush: bubbles every cycle it is high.
      for (int k = 0; k < 4; k++) begin
         step(0, 1, 64'h77);
         chk($sformatf("hold%0d.d1", k), {v1, d1[62:0]}, 64'd0);
         chk($sformatf("hold%0d.d3", k), {v3, d3[62:0]}, 64'd0);
      end

      // Latency after flush release on DEPTH=3: count edges until valid_out.
      lat = 0;
      rst = 0; flush = 0; data_in = 64'h1234;
      while (!v3 && lat < 10) begin
         @(posedge clk); @(negedge clk);
         lat++;
         data_in = 64'h5555;
      end
      chk("lat3.edges", 64'(lat), 64'd3);
      chk("lat3.data", d3, 64'h1234);

      // Reset mid-stream clears the full DEPTH=3 pipe, then first edge accepts.
      step(1, 0, 64'h99);
      chk("midrst.d3", {v3, d3[62:0]}, 64'd0);
      chk("midrst.d1", {v1, d1[62:0]}, 64'd0);
      step(0, 0, 64'hAB);
      chk("postrst.d1", d1, 64'hAB);
      chk("postrst.v1", {63'd0, v1}, 64'd1);

`ifdef BUFFER_MEMORY_FLUSH_CNT_EN
      // Three separate single-cycle flushes from a cleared counter.
      step(1, 0, 64'd0);
      for (int k = 0; k < 3; k++) begin
         step(0, 1, 64'd0);
         step(0, 0, 64'd0);
      end
      chk("cnt3flush", {48'd0, c1}, 64'd3);
      // Saturation: far more than 0xFFFF flushes holds at 0xFFFF.
      rst = 0; flush = 1;
      repeat (65540) @(posedge clk);
      @(negedge clk);
      chk("cnt_sat", {48'd0, c3}, 64'hFFFF);
      step(1, 1, 64'd0);
      chk("cnt_clr", {48'd0, c3}, 64'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
